// File: rtl/csr_port_arbiter.sv
// Two-port CSR access arbiter: port 0 (trap/commit) is preferred, port 1
// (execute) is forced through after STARVE_LIMIT losses. One transaction in
// flight: permission check, read of the old value, optional read-modify-write,
// then a response held until the requester takes it.
module csr_port_arbiter #(
   parameter int unsigned CSR_ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned STARVE_LIMIT   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   // request port 0 (trap/commit)
   input  logic                      req0_valid,
   output logic                      req0_ready,
   input  logic [CSR_ADDR_WIDTH-1:0] req0_addr,
   input  logic [1:0]                req0_op,
   input  logic [DATA_WIDTH-1:0]     req0_wdata,
   // request port 1 (execute)
   input  logic                      req1_valid,
   output logic                      req1_ready,
   input  logic [CSR_ADDR_WIDTH-1:0] req1_addr,
   input  logic [1:0]                req1_op,
   input  logic [DATA_WIDTH-1:0]     req1_wdata,
   // response ports
   output logic                      resp0_valid,
   input  logic                      resp0_ready,
   output logic [DATA_WIDTH-1:0]     resp0_rdata,
   output logic                      resp0_illegal,
   output logic                      resp1_valid,
   input  logic                      resp1_ready,
   output logic [DATA_WIDTH-1:0]     resp1_rdata,
   output logic                      resp1_illegal,
   // permission checker
   output logic [CSR_ADDR_WIDTH-1:0] chk_addr,
   input  logic                      chk_read_ok,
   input  logic                      chk_write_ok,
   // CSR file
   output logic                      csr_re,
   output logic [CSR_ADDR_WIDTH-1:0] csr_raddr,
   input  logic [DATA_WIDTH-1:0]     csr_rdata,
   output logic                      csr_we,
   output logic [CSR_ADDR_WIDTH-1:0] csr_waddr,
   output logic [DATA_WIDTH-1:0]     csr_wdata,
   // pipeline flush, only kills port-1 work still in READ
   input  logic                      flush
);

   localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SET   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      r_rst_q;
   logic [CNT_W-1:0]          r_starve_cnt;
   logic                      r_port;
   logic [CSR_ADDR_WIDTH-1:0] r_addr;
   logic [1:0]                r_op;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic                      r_rd_ok;
   logic                      r_wr_ok;
   logic [DATA_WIDTH-1:0]     r_old;

   logic                      w_p1_ok;
   logic                      w_force1;
   logic                      w_gnt0;
   logic                      w_gnt1;
   logic                      w_can_acc;
   logic                      w_acc0;
   logic                      w_acc1;
   logic                      w_acc;
   logic [CSR_ADDR_WIDTH-1:0] w_sel_addr;
   logic [1:0]                w_sel_op;
   logic [DATA_WIDTH-1:0]     w_sel_wdata;
   logic                      w_sel_illegal;
   logic                      w_wi;
   logic                      w_illegal;
   logic                      w_resp_ready;
   logic [DATA_WIDTH-1:0]     w_new;

   // Set/clear with an all-zero mask leaves the CSR untouched, so it only reads.
   function automatic logic f_write_intent(input logic [1:0] op,
                                           input logic [DATA_WIDTH-1:0] wd);
      return (op == OP_WRITE) || (op[1] && (wd != '0));
   endfunction

   // Arbitration: port 0 wins ties unless port 1 has hit its starvation limit.
   assign w_p1_ok   = req1_valid && !flush;
   assign w_force1  = w_p1_ok && (r_starve_cnt == CNT_W'(STARVE_LIMIT));
   assign w_gnt1    = w_p1_ok && (!req0_valid || w_force1);
   assign w_gnt0    = req0_valid && !w_gnt1;
   // No acceptance while in reset or in the cycle right after it.
   assign w_can_acc = (r_state == S_IDLE) && !rst && !r_rst_q;
   assign w_acc0    = w_can_acc && w_gnt0;
   assign w_acc1    = w_can_acc && w_gnt1;
   assign w_acc     = w_acc0 || w_acc1;

   assign w_sel_addr    = w_gnt1 ? req1_addr  : req0_addr;
   assign w_sel_op      = w_gnt1 ? req1_op    : req0_op;
   assign w_sel_wdata   = w_gnt1 ? req1_wdata : req0_wdata;
   assign w_sel_illegal = !chk_read_ok ||
                          (f_write_intent(w_sel_op, w_sel_wdata) && !chk_write_ok);

   assign w_wi         = f_write_intent(r_op, r_wdata);
   assign w_illegal    = !r_rd_ok || (w_wi && !r_wr_ok);
   assign w_resp_ready = r_port ? resp1_ready : resp0_ready;

   // Read-modify-write value; csr_rdata is the old value during WRITE.
   always_comb begin
      w_new = r_wdata;
      case (r_op)
         OP_SET:   w_new = csr_rdata | r_wdata;
         OP_CLEAR: w_new = csr_rdata & ~r_wdata;
         default:  w_new = r_wdata;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_acc) w_state_nxt = w_sel_illegal ? S_RESP : S_READ;
         S_READ:  w_state_nxt = (flush && r_port) ? S_IDLE : S_WRITE;
         S_WRITE: w_state_nxt = S_RESP;
         S_RESP:  if (w_resp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode; rst blanks every strobe during the reset cycle itself.
   always_comb begin
      req0_ready    = w_acc0;
      req1_ready    = w_acc1;
      chk_addr      = '0;
      csr_re        = 1'b0;
      csr_raddr     = r_addr;
      csr_we        = 1'b0;
      csr_waddr     = r_addr;
      csr_wdata     = w_new;
      resp0_valid   = 1'b0;
      resp1_valid   = 1'b0;
      resp0_rdata   = '0;
      resp1_rdata   = '0;
      resp0_illegal = 1'b0;
      resp1_illegal = 1'b0;
      if (r_state == S_IDLE) begin
         if (w_gnt0 || w_gnt1) chk_addr = w_sel_addr;
      end else begin
         chk_addr = r_addr;
      end
      if (!rst) begin
         csr_re      = (r_state == S_READ);
         csr_we      = (r_state == S_WRITE) && w_wi;
         resp0_valid = (r_state == S_RESP) && !r_port;
         resp1_valid = (r_state == S_RESP) && r_port;
      end
      if (resp0_valid) begin
         resp0_rdata   = r_old;
         resp0_illegal = w_illegal;
      end
      if (resp1_valid) begin
         resp1_rdata   = r_old;
         resp1_illegal = w_illegal;
      end
   end

   // Transaction latch, old-value capture and starvation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
         r_port       <= 1'b0;
         r_addr       <= '0;
         r_op         <= OP_READ;
         r_wdata      <= '0;
         r_rd_ok      <= 1'b0;
         r_wr_ok      <= 1'b0;
         r_old        <= '0;
      end else begin
         if (w_acc) begin
            r_port  <= w_acc1;
            r_addr  <= w_sel_addr;
            r_op    <= w_sel_op;
            r_wdata <= w_sel_wdata;
            r_rd_ok <= chk_read_ok;
            r_wr_ok <= chk_write_ok;
            r_old   <= '0;
         end
         if (r_state == S_WRITE) r_old <= csr_rdata;
         if (w_acc1) begin
            r_starve_cnt <= '0;
         end else if (w_acc0 && req1_valid &&
                      (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
         end
      end
   end

   // Remembers that the previous edge was a reset edge.
   always_ff @(posedge clk) begin
      r_rst_q <= rst;
   end

endmodule

// File: tb/tb_csr_port_arbiter.sv
// Directed bench for csr_port_arbiter: per-cycle vector table plus
// hand-written sequences for starvation, flush and reset corner cases.
module tb_csr_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [11:0] req0_addr, req1_addr;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_wdata, req1_wdata;
   logic        resp0_valid, resp0_ready, resp0_illegal;
   logic        resp1_valid, resp1_ready, resp1_illegal;
   logic [31:0] resp0_rdata, resp1_rdata;
   logic [11:0] chk_addr;
   logic        chk_read_ok, chk_write_ok;
   logic        csr_re, csr_we;
   logic [11:0] csr_raddr, csr_waddr;
   logic [31:0] csr_rdata, csr_wdata;
   logic        flush;

   always #5 clk = ~clk;

   csr_port_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_op(req0_op), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_op(req1_op), .req1_wdata(req1_wdata),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp0_rdata(resp0_rdata), .resp0_illegal(resp0_illegal),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp1_rdata(resp1_rdata), .resp1_illegal(resp1_illegal),
      .chk_addr(chk_addr), .chk_read_ok(chk_read_ok), .chk_write_ok(chk_write_ok),
      .csr_re(csr_re), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
      .flush(flush)
   );

   typedef struct {
      logic rst, v0, v1;
      logic [1:0] op0, op1;
      logic [11:0] a0, a1;
      logic [31:0] wd0, wd1;
      logic rok, wok;
      logic [31:0] crd;
      logic fl, rr0, rr1;
   } in_t;

   typedef struct {
      logic rdy0, rdy1, re, we;
      logic [31:0] wdat;
      logic rv0, rv1;
      logic [31:0] rdat;
      logic ill;
      logic [11:0] caddr;
   } exp_t;

   in_t  vin[$];
   exp_t vexp[$];
   in_t  ci;
   exp_t ce;
   int   n_cmp = 0;
   int   n_err = 0;
   logic mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic clr();
      ci.rst = 0; ci.v0 = 0; ci.v1 = 0; ci.op0 = 2'b00; ci.op1 = 2'b00;
      ci.a0 = 12'h0; ci.a1 = 12'h0; ci.wd0 = 32'h0; ci.wd1 = 32'h0;
      ci.rok = 1; ci.wok = 1; ci.crd = 32'h0; ci.fl = 0; ci.rr0 = 1; ci.rr1 = 1;
      ce.rdy0 = 0; ce.rdy1 = 0; ce.re = 0; ce.we = 0; ce.wdat = 32'h0;
      ce.rv0 = 0; ce.rv1 = 0; ce.rdat = 32'h0; ce.ill = 0; ce.caddr = 12'h0;
   endtask

   task automatic push();
      vin.push_back(ci);
      vexp.push_back(ce);
   endtask

   task automatic drive(input in_t i);
      rst = i.rst; req0_valid = i.v0; req1_valid = i.v1;
      req0_op = i.op0; req1_op = i.op1; req0_addr = i.a0; req1_addr = i.a1;
      req0_wdata = i.wd0; req1_wdata = i.wd1;
      chk_read_ok = i.rok; chk_write_ok = i.wok; csr_rdata = i.crd;
      flush = i.fl; resp0_ready = i.rr0; resp1_ready = i.rr1;
   endtask

   task automatic check_row(input int idx, input exp_t e);
      string p;
      p = $sformatf("row%0d", idx);
      chk({p, ".req0_ready"}, 32'(req0_ready), 32'(e.rdy0));
      chk({p, ".req1_ready"}, 32'(req1_ready), 32'(e.rdy1));
      chk({p, ".csr_re"}, 32'(csr_re), 32'(e.re));
      chk({p, ".csr_we"}, 32'(csr_we), 32'(e.we));
      if (e.we) chk({p, ".csr_wdata"}, csr_wdata, e.wdat);
      chk({p, ".resp0_valid"}, 32'(resp0_valid), 32'(e.rv0));
      chk({p, ".resp1_valid"}, 32'(resp1_valid), 32'(e.rv1));
      chk({p, ".resp0_rdata"}, resp0_rdata, e.rv0 ? e.rdat : 32'h0);
      chk({p, ".resp1_rdata"}, resp1_rdata, e.rv1 ? e.rdat : 32'h0);
      chk({p, ".resp0_illegal"}, 32'(resp0_illegal), 32'(e.rv0 ? e.ill : 1'b0));
      chk({p, ".resp1_illegal"}, 32'(resp1_illegal), 32'(e.rv1 ? e.ill : 1'b0));
      chk({p, ".chk_addr"}, 32'(chk_addr), 32'(e.caddr));
      if (e.re) chk({p, ".csr_raddr"}, 32'(csr_raddr), 32'(e.caddr));
      if (e.we) chk({p, ".csr_waddr"}, 32'(csr_waddr), 32'(e.caddr));
   endtask

   // csr_re, csr_we and the response valids are mutually exclusive.
   always @(negedge clk) begin
      #2;
      if (mon_en)
         chk("onehot_strobes",
             32'(int'(csr_re) + int'(csr_we) + int'(resp0_valid) + int'(resp1_valid) > 1),
             32'h0);
   end

   initial begin
      int   got[$];
      int   exp_order[10];
      int   cyc;

      clr();
      ci.rst = 1;
      drive(ci);
      repeat (2) @(posedge clk);

      // reset cycle, then the cycle after reset: no acceptance yet
      clr(); ci.rst = 1; ci.v0 = 1; ci.op0 = 2'b10; ci.a0 = 12'h300; ci.wd0 = 32'h8;
      ce.caddr = 12'h300; push();
      clr(); ci.v0 = 1; ci.op0 = 2'b10; ci.a0 = 12'h300; ci.wd0 = 32'h8;
      ce.caddr = 12'h300; push();
      // port 0 set 0x300 |= 0x8 on old 0x1
      clr(); ci.v0 = 1; ci.op0 = 2'b10; ci.a0 = 12'h300; ci.wd0 = 32'h8;
      ce.rdy0 = 1; ce.caddr = 12'h300; push();
      clr(); ce.re = 1; ce.caddr = 12'h300; push();
      clr(); ci.crd = 32'h1; ce.we = 1; ce.wdat = 32'h9; ce.caddr = 12'h300; push();
      // response held 5 cycles with both requesters waiting
      for (int k = 0; k < 5; k++) begin
         clr(); ci.rr0 = 0; ci.v0 = 1; ci.v1 = 1; ci.a1 = 12'h001; ci.crd = 32'hDEADBEEF;
         ce.rv0 = 1; ce.rdat = 32'h1; ce.caddr = 12'h300; push();
      end
      // handshake cycle: still no grant
      clr(); ci.v0 = 1; ci.v1 = 1; ci.crd = 32'hDEADBEEF;
      ce.rv0 = 1; ce.rdat = 32'h1; ce.caddr = 12'h300; push();
      // port 1 write to 0xF11 without write permission -> illegal
      clr(); ci.v1 = 1; ci.op1 = 2'b01; ci.a1 = 12'hF11; ci.wd1 = 32'h5; ci.wok = 0;
      ce.rdy1 = 1; ce.caddr = 12'hF11; push();
      clr(); ce.rv1 = 1; ce.ill = 1; ce.rdat = 32'h0; ce.caddr = 12'hF11; push();
      // port 1 clear with zero mask is a legal read
      clr(); ci.v1 = 1; ci.op1 = 2'b11; ci.a1 = 12'h305; ci.wd1 = 32'h0; ci.wok = 0;
      ce.rdy1 = 1; ce.caddr = 12'h305; push();
      clr(); ce.re = 1; ce.caddr = 12'h305; push();
      clr(); ci.crd = 32'h77; ce.caddr = 12'h305; push();
      clr(); ce.rv1 = 1; ce.rdat = 32'h77; ce.caddr = 12'h305; push();
      // port 0 read without read permission -> illegal
      clr(); ci.v0 = 1; ci.op0 = 2'b00; ci.a0 = 12'h7C0; ci.rok = 0;
      ce.rdy0 = 1; ce.caddr = 12'h7C0; push();
      clr(); ce.rv0 = 1; ce.ill = 1; ce.caddr = 12'h7C0; push();
      clr(); push();
      // port 0 clear 0x0F on old 0xFF
      clr(); ci.v0 = 1; ci.op0 = 2'b11; ci.a0 = 12'h344; ci.wd0 = 32'h0F;
      ce.rdy0 = 1; ce.caddr = 12'h344; push();
      clr(); ce.re = 1; ce.caddr = 12'h344; push();
      clr(); ci.crd = 32'hFF; ce.we = 1; ce.wdat = 32'hF0; ce.caddr = 12'h344; push();
      clr(); ce.rv0 = 1; ce.rdat = 32'hFF; ce.caddr = 12'h344; push();
      // port 1 plain write
      clr(); ci.v1 = 1; ci.op1 = 2'b01; ci.a1 = 12'h340; ci.wd1 = 32'hABCD;
      ce.rdy1 = 1; ce.caddr = 12'h340; push();
      clr(); ce.re = 1; ce.caddr = 12'h340; push();
      clr(); ci.crd = 32'h1234; ce.we = 1; ce.wdat = 32'hABCD; ce.caddr = 12'h340; push();
      clr(); ce.rv1 = 1; ce.rdat = 32'h1234; ce.caddr = 12'h340; push();
      // flush blocks a port-1 grant in IDLE
      clr(); ci.v1 = 1; ci.a1 = 12'h111; ci.fl = 1; push();
      clr(); push();

      mon_en = 1'b1;
      foreach (vin[i]) begin
         @(negedge clk);
         drive(vin[i]);
         #1;
         check_row(i, vexp[i]);
      end

      // flush during READ of a port-1 write: no write, no response, IDLE next
      @(negedge clk);
      clr(); ci.v1 = 1; ci.op1 = 2'b01; ci.a1 = 12'h340; ci.wd1 = 32'h55; drive(ci);
      #1 chk("fl.accept", 32'(req1_ready), 32'h1);
      @(negedge clk);
      ci.v1 = 0; ci.fl = 1; drive(ci);
      @(negedge clk);
      ci.v1 = 1; ci.fl = 0; drive(ci);
      #1;
      chk("fl.idle_ready", 32'(req1_ready), 32'h1);
      chk("fl.no_we", 32'(csr_we), 32'h0);
      chk("fl.no_resp", 32'(resp1_valid), 32'h0);
      // flush during WRITE and RESP does not abort
      @(negedge clk);
      ci.v1 = 0; drive(ci);
      #1 chk("flw.re", 32'(csr_re), 32'h1);
      @(negedge clk);
      ci.fl = 1; ci.crd = 32'h10; drive(ci);
      #1;
      chk("flw.we", 32'(csr_we), 32'h1);
      chk("flw.wdata", csr_wdata, 32'h55);
      @(negedge clk);
      #1;
      chk("flw.resp1_valid", 32'(resp1_valid), 32'h1);
      chk("flw.resp1_rdata", resp1_rdata, 32'h10);
      @(negedge clk);
      clr(); drive(ci);

      // starvation: both ports valid continuously
      exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      @(negedge clk);
      clr(); ci.v0 = 1; ci.v1 = 1; ci.a0 = 12'h010; ci.a1 = 12'h020; drive(ci);
      cyc = 0;
      while (got.size() < 10 && cyc < 100) begin
         #1;
         if (req0_ready) got.push_back(0);
         if (req1_ready) got.push_back(1);
         @(negedge clk);
         cyc++;
      end
      chk("starve.grant_count", 32'(got.size()), 32'd10);
      for (int i = 0; i < 10; i++)
         if (i < got.size()) chk($sformatf("starve.grant%0d", i), 32'(got[i]), 32'(exp_order[i]));

      // reset while a response is pending
      clr(); drive(ci);
      repeat (5) @(negedge clk);
      clr(); ci.v0 = 1; ci.a0 = 12'h123; drive(ci);
      #1 chk("rstr.accept", 32'(req0_ready), 32'h1);
      @(negedge clk);
      ci.v0 = 0; ci.rr0 = 0; drive(ci);
      @(negedge clk);
      ci.crd = 32'h5A; drive(ci);
      @(negedge clk);
      #1;
      chk("rstr.resp0_valid", 32'(resp0_valid), 32'h1);
      chk("rstr.resp0_rdata", resp0_rdata, 32'h5A);
      @(negedge clk);
      ci.rst = 1; drive(ci);
      #1 chk("rstr.in_rst_valid", 32'(resp0_valid), 32'h0);
      @(negedge clk);
      ci.rst = 0; ci.v0 = 1; drive(ci);
      #1;
      chk("rstr.after_valid", 32'(resp0_valid), 32'h0);
      chk("rstr.after_rdata", resp0_rdata, 32'h0);
      chk("rstr.after_illegal", 32'(resp0_illegal), 32'h0);
      chk("rstr.after_ready", 32'(req0_ready), 32'h0);
      chk("rstr.after_re", 32'(csr_re), 32'h0);
      chk("rstr.after_we", 32'(csr_we), 32'h0);
      @(negedge clk);
      #1 chk("rstr.ready_again", 32'(req0_ready), 32'h1);
      @(negedge clk);
      clr(); drive(ci);
      mon_en = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/csr_port_arbiter.md
CSR_PORT_ARBITER -- requirements
Module: csr_port_arbiter

Interface
REQ-001 SHALL have parameter CSR_ADDR_WIDTH, default 12: CSR address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: CSR data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: consecutive port-0 wins over a waiting port 1 before port 1 is forced.
REQ-004 SHALL have ports clk (input, 1, clock) and rst (input, 1, synchronous active-high reset); one clock domain.
REQ-005 SHALL have, for N in {0,1}: reqN_valid (in, 1); reqN_ready (out, 1); reqN_addr (in, CSR_ADDR_WIDTH); reqN_op (in, 2: 00 read, 01 write, 10 set, 11 clear); reqN_wdata (in, DATA_WIDTH). Port 0 is trap/commit, port 1 is the execute CSR unit.
REQ-006 SHALL have, for N in {0,1}: respN_valid (out, 1); respN_ready (in, 1); respN_rdata (out, DATA_WIDTH, old CSR value); respN_illegal (out, 1).
REQ-007 SHALL have chk_addr (out, CSR_ADDR_WIDTH), chk_read_ok (in, 1) and chk_write_ok (in, 1); the permit inputs are combinational functions of chk_addr.
REQ-008 SHALL have csr_re (out, 1), csr_raddr (out, CSR_ADDR_WIDTH), csr_rdata (in, DATA_WIDTH, valid the cycle after csr_re), csr_we (out, 1), csr_waddr (out, CSR_ADDR_WIDTH), csr_wdata (out, DATA_WIDTH).
REQ-009 SHALL have flush (in, 1): kills an in-flight port-1 transaction.

Function
REQ-010 SHALL implement FSM states IDLE, READ, WRITE, RESP; one transaction in flight at a time.
REQ-011 In IDLE the arbiter SHALL grant port 0 when only req0_valid, port 1 when only req1_valid (and not flush), and port 0 when both, unless starve_cnt == STARVE_LIMIT, in which case port 1.
REQ-012 reqN_ready SHALL be 1 only in IDLE for the granted port; acceptance is reqN_valid && reqN_ready.
REQ-013 starve_cnt SHALL increment, saturating at STARVE_LIMIT, when port 0 is accepted while req1_valid=1, and clear to 0 when port 1 is accepted.
REQ-014 chk_addr SHALL equal the granted port's address in IDLE (0 if no grant) and the latched address otherwise.
REQ-015 On acceptance the block SHALL latch port id, addr, op, wdata, chk_read_ok and chk_write_ok.
REQ-016 A transaction is a write-intent if op=01, or op is set/clear with wdata != 0; set/clear with wdata == 0 is read-only.
REQ-017 Illegal SHALL be: !read_ok, or (write-intent && !write_ok). Illegal: IDLE->RESP, no csr_re, no csr_we, rdata=0, illegal=1.
REQ-018 Legal: IDLE->READ; in READ csr_re=1, csr_raddr=latched addr, for exactly one cycle; READ->WRITE.
REQ-019 In WRITE the block SHALL capture csr_rdata as old; if write-intent, csr_we=1 for that one cycle with csr_waddr=addr and csr_wdata = wdata (write), old|wdata (set), or old&~wdata (clear); WRITE->RESP.
REQ-020 In RESP respN_valid=1 for the latched port only, with rdata=old and illegal=0 (legal case); it SHALL hold, with rdata stable, until respN_ready=1, then go to IDLE.
REQ-021 Legal accept-to-resp_valid latency SHALL be 3 cycles; illegal latency 1 cycle.
REQ-022 flush in READ with a port-1 transaction SHALL return to IDLE without csr_we or response; flush in WRITE or RESP SHALL NOT abort; flush never affects port 0.
REQ-023 A new request SHALL NOT be accepted in the same cycle a response is handshaken (IDLE is entered first).
REQ-024 csr_re, csr_we and respN_valid SHALL never be asserted in the same cycle as one another.

Reset
REQ-025 When rst=1 at a rising clk: state=IDLE, starve_cnt=0, latched fields=0; during that cycle and the next, reqN_ready=0, respN_valid=0, csr_re=0, csr_we=0, rdata=0, illegal=0.
REQ-026 rst mid-transaction SHALL abandon it with no further csr_we or response.

Verification
REQ-027 Port 0 set op, addr 0x300, wdata 0x8, csr_rdata 0x1 -> csr_we at accept+2, csr_wdata 0x9; resp0_valid at accept+3 with rdata 0x1, illegal 0.
REQ-028 Port 1 write, addr 0xF11, chk_write_ok=0 -> resp1_valid at accept+1, illegal 1, rdata 0; no csr_re or csr_we.
REQ-029 Port 1 clear, wdata 0, chk_write_ok=0, chk_read_ok=1 -> legal read; csr_re asserted, no csr_we, illegal 0.
REQ-030 Both ports valid continuously, STARVE_LIMIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1,...
REQ-031 Port 1 transaction, flush during READ -> no csr_we, no resp1_valid, IDLE next cycle; a flush during WRITE still writes and responds.
REQ-032 resp0_ready held 0 for 5 cycles -> resp0_valid and rdata stable, no new grant; rst asserted mid-RESP -> next cycle all outputs 0.
